// File: rtl/modexp_decrypt_seq_if.sv
// ---------------------------------------------------------------------------
// modexp_decrypt_seq_if
// Handshake and operand bundle for the RSA decryption engine (m = c^d mod n).
//   start : request pulse from the ciphertext side (master -> slave)
//   c,d,n : ciphertext, private exponent, modulus (master -> slave)
//   busy  : engine working, through the done cycle (slave -> master)
//   done  : one-cycle pulse, m/err valid (slave -> master)
//   err   : illegal request (n==0 or c>=n) (slave -> master)
//   m     : plaintext, held until the next completion (slave -> master)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface modexp_decrypt_seq_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] n;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] m;

    modport master (output start, c, d, n, input busy, done, err, m);
    modport slave  (input start, c, d, n, output busy, done, err, m);
endinterface

// File: rtl/modexp_decrypt_seq.sv
// ---------------------------------------------------------------------------
// modexp_decrypt_seq
// RSA decryption engine computing m = c^d mod n with a constant-latency
// left-to-right square-and-always-multiply schedule. Each modular product is
// formed by a bit-serial interleaved multiplier consuming one multiplier bit
// per cycle, so every legal request takes the same number of clocks.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : modexp_decrypt_seq_if.slave (start/c/d/n in, busy/done/err/m out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module modexp_decrypt_seq #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    modexp_decrypt_seq_if.slave  bus
);

    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {IDLE, CHK, SQR, MUL, FIN} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [N-1:0]    r_c;
    logic [N-1:0]    r_d;
    logic [N-1:0]    r_n;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    r_prod;
    logic [CW-1:0]   r_bit;
    logic [CW-1:0]   r_k;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [N-1:0]    r_m;

    logic            w_illegal;
    logic            w_lastBit;
    logic [N-1:0]    w_y;
    logic [N-1:0]    w_pBase;
    logic [N+1:0]    w_nExt;
    logic [N+1:0]    w_sum;
    logic [N+1:0]    w_sub1;
    logic [N-1:0]    w_prodNext;

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.m    = r_m;

    // Request legality and the one-bit-per-cycle interleaved multiplier step.
    // The multiplier operand x is always acc; the multiplicand is acc while
    // squaring and the latched ciphertext while multiplying. The partial
    // product restarts from zero on the top bit. Because P<n on entry,
    // 2P+y < 3n, so two conditional subtracts restore P<n and N+2 bits
    // never overflow; the second result always fits back in N bits.
    always_comb begin
        w_illegal  = (r_n == '0) || (r_c >= r_n);
        w_lastBit  = (r_bit == '0);
        w_y        = (r_state == SQR) ? r_acc : r_c;
        w_pBase    = (r_bit == CW'(N-1)) ? '0 : r_prod;
        w_nExt     = {2'b00, r_n};
        w_sum      = ({2'b00, w_pBase} << 1) + (r_acc[r_bit] ? {2'b00, w_y} : '0);
        w_sub1     = (w_sum >= w_nExt) ? (w_sum - w_nExt) : w_sum;
        w_prodNext = (w_sub1 >= w_nExt) ? N'(w_sub1 - w_nExt) : w_sub1[N-1:0];
    end

    // Next-state logic. SQR and MUL each last N cycles (one multiplier bit
    // per cycle); the exponent bit only gates whether MUL's product is kept,
    // never the schedule, so latency does not depend on d.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_nextState = CHK;
            CHK:  w_nextState = w_illegal ? FIN : SQR;
            SQR:  if (w_lastBit) w_nextState = MUL;
            MUL:  if (w_lastBit) w_nextState = (r_k == '0) ? FIN : SQR;
            FIN:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State and datapath registers. Outputs are registered on the edge that
    // enters FIN, so done/m/err are all valid during the FIN cycle; busy
    // rises leaving CHK and falls leaving FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_n     <= '0;
            r_acc   <= '0;
            r_prod  <= '0;
            r_bit   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_m     <= '0;
        end else begin
            r_state <= w_nextState;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_c <= bus.c;
                        r_d <= bus.d;
                        r_n <= bus.n;
                    end
                end
                CHK: begin
                    r_err  <= w_illegal;
                    r_busy <= 1'b1;
                    r_bit  <= CW'(N-1);
                    r_k    <= CW'(N-1);
                    r_acc  <= (r_n == N'(1)) ? '0 : N'(1);
                    if (w_illegal) begin
                        r_done <= 1'b1;
                        r_m    <= '0;
                    end
                end
                SQR, MUL: begin
                    r_prod <= w_prodNext;
                    if (w_lastBit) begin
                        r_bit <= CW'(N-1);
                        if ((r_state == SQR) || r_d[r_k]) r_acc <= w_prodNext;
                        if (r_state == MUL) begin
                            if (r_k == '0) begin
                                r_done <= 1'b1;
                                r_m    <= r_d[r_k] ? w_prodNext : r_acc;
                            end else begin
                                r_k <= r_k - 1'b1;
                            end
                        end
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                FIN: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
